// File: rtl/rainbow_sequencer.sv
// rtl/rainbow_sequencer.sv - six-phase RGB hue-wheel sequencer driving PWM ramp-direction flags.
// Optional STT watchdog compiled in with RAINBOW_WATCHDOG_EN.
module rainbow_sequencer #(
  parameter logic [3:0]  DWELL   = 4'd1,
  parameter logic [25:0] TIMEOUT = 26'd40_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic       STT_R,
  input  logic       STT_G,
  input  logic       STT_B,
  output logic       FLAG_R,
  output logic       FLAG_G,
  output logic       FLAG_B,
  output logic [2:0] PHASE,
  output logic       STEP,
  output logic       FAULT
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [3:0] DWELL_LIM = (DWELL == 4'd0) ? 4'd1 : DWELL;

  state_t     r_state, w_state_next;
  logic [2:0] r_phase, w_phase_next;
  logic [3:0] r_dwell, w_dwell_next;
  logic [2:0] r_flag, w_flag_next;
  logic       r_step, w_step_next;
  logic       w_pace;
  logic       w_advance;
  logic       w_timeout;

`ifdef RAINBOW_WATCHDOG_EN
  logic [25:0] r_wdog, w_wdog_next;
  logic        r_fault, w_fault_next;

  assign w_timeout = (r_wdog == TIMEOUT - 26'd1);

  // A pacing STT in the timeout cycle takes priority, so no fault is raised.
  always_comb begin
    w_wdog_next  = 26'd0;
    w_fault_next = r_fault;
    if (r_state == S_RUN && ENABLE) begin
      if (w_pace) begin
        w_wdog_next = 26'd0;
      end else if (w_timeout) begin
        w_wdog_next  = 26'd0;
        w_fault_next = 1'b1;
      end else begin
        w_wdog_next = r_wdog + 26'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wdog  <= 26'd0;
      r_fault <= 1'b0;
    end else begin
      r_wdog  <= w_wdog_next;
      r_fault <= w_fault_next;
    end
  end

  assign FAULT = r_fault;
`else
  assign w_timeout = 1'b0;
  // TIMEOUT has no effect without the watchdog; referenced only to keep it bound.
  assign FAULT     = 1'b0 & (TIMEOUT == 26'd0);
`endif

  always_comb begin
    case (r_phase)
      3'd0, 3'd3: w_pace = STT_R;
      3'd1, 3'd4: w_pace = STT_G;
      default:    w_pace = STT_B;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_dwell_next = r_dwell;
    w_step_next  = 1'b0;
    w_advance    = 1'b0;
    w_flag_next  = 3'b000;
    case (r_state)
      S_IDLE: begin
        w_phase_next = 3'd0;
        w_dwell_next = 4'd0;
        if (ENABLE) w_state_next = S_RUN;
      end
      default: begin
        if (!ENABLE) begin
          w_state_next = S_IDLE;
          w_phase_next = 3'd0;
          w_dwell_next = 4'd0;
        end else if (w_pace) begin
          if (r_dwell == DWELL_LIM - 4'd1) begin
            w_advance    = 1'b1;
            w_dwell_next = 4'd0;
          end else begin
            w_dwell_next = r_dwell + 4'd1;
          end
        end else if (w_timeout) begin
          w_advance    = 1'b1;
          w_dwell_next = 4'd0;
        end
      end
    endcase
    if (w_advance) begin
      w_phase_next = (r_phase == 3'd5) ? 3'd0 : r_phase + 3'd1;
      w_step_next  = 1'b1;
    end
    // Flags are registered from the upcoming phase so they change with PHASE.
    if (w_state_next == S_RUN) begin
      case (w_phase_next)
        3'd0:    w_flag_next = 3'b100;
        3'd1:    w_flag_next = 3'b110;
        3'd2:    w_flag_next = 3'b010;
        3'd3:    w_flag_next = 3'b011;
        3'd4:    w_flag_next = 3'b001;
        default: w_flag_next = 3'b101;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_phase <= 3'd0;
      r_dwell <= 4'd0;
      r_flag  <= 3'b000;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      r_dwell <= w_dwell_next;
      r_flag  <= w_flag_next;
      r_step  <= w_step_next;
    end
  end

  assign {FLAG_R, FLAG_G, FLAG_B} = r_flag;
  assign PHASE = r_phase;
  assign STEP  = r_step;

endmodule

// File: tb/tb_rainbow_sequencer.sv
// tb/tb_rainbow_sequencer.sv - directed and randomized bench for rainbow_sequencer against a behavioural model.
// Watchdog scenarios run only when RAINBOW_WATCHDOG_EN is defined.
module tb_rainbow_sequencer;

  localparam int DWELL   = 2;
  localparam int TIMEOUT = 100;
`ifdef RAINBOW_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       ENABLE = 1'b0;
  logic       STT_R = 1'b0, STT_G = 1'b0, STT_B = 1'b0;
  logic       FLAG_R, FLAG_G, FLAG_B;
  logic [2:0] PHASE;
  logic       STEP;
  logic       FAULT;

  rainbow_sequencer #(.DWELL(4'(DWELL)), .TIMEOUT(26'(TIMEOUT))) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
    .STT_R(STT_R), .STT_G(STT_G), .STT_B(STT_B),
    .FLAG_R(FLAG_R), .FLAG_G(FLAG_G), .FLAG_B(FLAG_B),
    .PHASE(PHASE), .STEP(STEP), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  // Hue wheel: flag pattern per phase; pacing channel is phase mod 3 (0=R, 1=G, 2=B).
  logic [2:0] hue [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

  int checks   = 0;
  int failures = 0;
  int n_steps  = 0;

  bit m_run = 0;
  int m_phase = 0, m_cnt = 0, m_wd = 0;
  bit m_step = 0, m_fault = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] pace_bits();
    logic [2:0] b;
    b = 3'b100;
    return b >> (m_phase % 3);
  endfunction

  task automatic model_step(input logic rst, input logic en, input logic [2:0] stt);
    if (rst) begin
      m_run = 0; m_phase = 0; m_cnt = 0; m_wd = 0; m_step = 0; m_fault = 0;
    end else if (!m_run || !en) begin
      m_run = en && !m_run; m_phase = 0; m_cnt = 0; m_wd = 0; m_step = 0;
    end else begin
      m_step = 0;
      if (stt[2 - (m_phase % 3)]) begin
        m_wd = 0;
        m_cnt++;
        if (m_cnt == DWELL) begin
          m_cnt = 0; m_phase = (m_phase + 1) % 6; m_step = 1;
        end
      end else if (WD && m_wd == TIMEOUT - 1) begin
        m_wd = 0; m_cnt = 0; m_phase = (m_phase + 1) % 6; m_step = 1; m_fault = 1;
      end else begin
        m_wd++;
      end
    end
  endtask

  task automatic tick(input logic rst, input logic en, input logic [2:0] stt);
    @(negedge CLK);
    RST = rst; ENABLE = en; {STT_R, STT_G, STT_B} = stt;
    model_step(rst, en, stt);
    @(posedge CLK);
    #1;
    chk("flag",  32'({FLAG_R, FLAG_G, FLAG_B}), 32'(m_run ? hue[m_phase] : 3'b000));
    chk("phase", 32'(PHASE), 32'(m_phase));
    chk("step",  32'(STEP),  32'(m_step));
    chk("fault", 32'(FAULT), 32'(m_fault));
    if (STEP) n_steps++;
  endtask

  task automatic restart();
    tick(1'b1, 1'b0, 3'b000);
    tick(1'b0, 1'b1, 3'b000);
  endtask

  initial begin
    // Reset for three cycles with noise on STT, then start.
    repeat (3) tick(1'b1, 1'b0, 3'($urandom_range(0, 7)));
    chk("reset_flag", 32'({FLAG_R, FLAG_G, FLAG_B}), 32'h0);
    chk("reset_phase", 32'(PHASE), 32'h0);
    tick(1'b0, 1'b1, 3'b000);
    chk("start_flag", 32'({FLAG_R, FLAG_G, FLAG_B}), 32'b100);
    chk("start_phase", 32'(PHASE), 32'h0);

    // Full wheel, two pacing pulses per phase.
    n_steps = 0;
    for (int p = 0; p < 6; p++) begin
      tick(1'b0, 1'b1, pace_bits());
      tick(1'b0, 1'b1, 3'b000);
      tick(1'b0, 1'b1, pace_bits());
      chk("wheel_flag", 32'({FLAG_R, FLAG_G, FLAG_B}), 32'(hue[(p + 1) % 6]));
    end
    chk("wheel_steps", 32'(n_steps), 32'd6);
    chk("wheel_wrap", 32'(PHASE), 32'd0);

    // Non-pacing channels in P0.
    n_steps = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 3'b010);
      tick(1'b0, 1'b1, 3'b001);
    end
    chk("nonpace_phase", 32'(PHASE), 32'd0);
    chk("nonpace_steps", 32'(n_steps), 32'd0);

    // Mid-run disable in P3 with dwell at 1.
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, pace_bits());
    chk("pre_disable_phase", 32'(PHASE), 32'd3);
    tick(1'b0, 1'b0, 3'b000);
    chk("idle_flag", 32'({FLAG_R, FLAG_G, FLAG_B}), 32'h0);
    chk("idle_phase", 32'(PHASE), 32'd0);
    tick(1'b0, 1'b1, 3'b000);
    tick(1'b0, 1'b1, 3'b100);
    chk("restart_hold", 32'(PHASE), 32'd0);
    tick(1'b0, 1'b1, 3'b100);
    chk("restart_adv", 32'(PHASE), 32'd1);

`ifdef RAINBOW_WATCHDOG_EN
    restart();
    repeat (99) tick(1'b0, 1'b1, 3'b000);
    chk("wd_before", 32'(PHASE), 32'd0);
    tick(1'b0, 1'b1, 3'b000);
    chk("wd_phase", 32'(PHASE), 32'd1);
    chk("wd_fault", 32'(FAULT), 32'd1);

    restart();
    tick(1'b0, 1'b1, 3'b100);
    repeat (99) tick(1'b0, 1'b1, 3'b000);
    tick(1'b0, 1'b1, 3'b100);
    chk("wd_coinc_phase", 32'(PHASE), 32'd1);
    chk("wd_coinc_fault", 32'(FAULT), 32'd0);
    repeat (100) tick(1'b0, 1'b1, 3'b000);
    chk("wd_fault_again", 32'(FAULT), 32'd1);
`endif

    // Reset in P4 with dwell at 1 and a coincident pacing pulse.
    for (int i = 0; i < 20 && m_phase != 4; i++) tick(1'b0, 1'b1, pace_bits());
    chk("pre_rst_phase", 32'(PHASE), 32'd4);
    tick(1'b0, 1'b1, pace_bits());
    tick(1'b1, 1'b1, pace_bits());
    chk("rst_phase", 32'(PHASE), 32'd0);
    chk("rst_flag", 32'({FLAG_R, FLAG_G, FLAG_B}), 32'h0);
    chk("rst_fault", 32'(FAULT), 32'd0);
    chk("rst_step", 32'(STEP), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] s;
      s[2] = ($urandom_range(0, 2) == 0);
      s[1] = ($urandom_range(0, 2) == 0);
      s[0] = ($urandom_range(0, 2) == 0);
      tick($urandom_range(0, 149) == 0, $urandom_range(0, 19) != 0, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rainbow_sequencer.md
# rainbow_sequencer

Phase sequencer for the three-channel RGB PWM fade. It drives the ramp-direction FLAG input of the red, green and blue PWM channels through a fixed six-phase hue wheel. Each phase advances on the end-of-ramp STT pulses that the channels return. It sits between the top level and the three PWM instances. An optional watchdog forces progress if the pacing channel's STT pulses stop arriving.

## Interface
Parameters:
- DWELL, 4'd1, number of pacing-channel STT pulses per phase (legal 1..15; 0 treated as 1)
- TIMEOUT, 26'd40_000_000, watchdog limit in CLK cycles without a pacing STT pulse (legal ≥ 2)

Ports:
- CLK  in  1  system clock; everything is rising-edge
- RST  in  1  synchronous, active-high reset
- ENABLE  in  1  1 = run the hue wheel, 0 = idle
- STT_R / STT_G / STT_B  in  1 each  one-cycle end-of-ramp pulses from the R/G/B PWM channels
- FLAG_R / FLAG_G / FLAG_B  out  1 each  ramp direction to each PWM channel (1 up, 0 down)
- PHASE  out  3  current phase, 0..5
- STEP  out  1  one-cycle pulse on every phase advance
- FAULT  out  1  sticky; set on a watchdog timeout

## Operation
- FSM has two states: IDLE and RUN.
- IDLE:
  - FLAG = 000, PHASE = 0, STEP = 0, dwell and watchdog counters held at 0.
  - Moves to RUN on the edge after ENABLE = 1 is sampled.
- RUN:
  - Outputs {FLAG_R, FLAG_G, FLAG_B} per phase: P0 = 100, P1 = 110, P2 = 010, P3 = 011, P4 = 001, P5 = 101.
  - Pacing channel is fixed by phase: P0/P3 = R, P1/P4 = G, P2/P5 = B. STT pulses from the non-pacing channels are ignored.
- Dwell counter (4 bits):
  - Increments on each pacing STT pulse.
  - When a pacing STT pulse arrives with the counter at DWELL−1, the block advances the phase, clears the counter and pulses STEP.
- Phase wrap: P5 advances to P0.
- ENABLE = 0 while in RUN: the next edge enters IDLE and clears all counters. FAULT is not cleared.
- RST: forces IDLE and clears FAULT and all counters, regardless of the other inputs.
- Watchdog (when compiled in):
  - 26-bit counter; increments every RUN cycle and clears on a pacing STT pulse or on a phase advance.
  - When the counter reaches TIMEOUT−1, it forces a phase advance (STEP = 1), clears the dwell counter and sets FAULT.
  - If a pacing STT pulse and the timeout occur in the same cycle, only one advance happens and the STT pulse wins: FAULT is not set.

## Timing
- Reset values: FLAG_R = FLAG_G = FLAG_B = 0, PHASE = 0, STEP = 0, FAULT = 0, FSM = IDLE.
- All outputs are registered.
- Start-up: ENABLE sampled at edge N gives FLAG = 100 after edge N.
- Phase advance:
  - A qualifying STT pulse sampled at edge N updates PHASE and FLAG after edge N.
  - STEP is high for exactly the one cycle following edge N.
- STT inputs are used unregistered within the same cycle and must be synchronous to CLK.
- Back-to-back pacing STT pulses on consecutive cycles are each counted. After an advance, the pacing channel changes immediately, so an STT pulse in the next cycle is judged against the new phase.
- Timeout: with no pacing STT, the advance occurs TIMEOUT cycles after entry to the phase or after the last pacing STT.

## Configuration
- RAINBOW_WATCHDOG_EN defined:
  - Watchdog counter and FAULT logic are present, as described above.
- RAINBOW_WATCHDOG_EN undefined:
  - No watchdog counter is built; FAULT is tied to 0 and the TIMEOUT parameter is ignored.
  - Phases advance only on pacing STT pulses; the sequencer waits indefinitely.

## Test plan
- Reset and start:
  - Stimulus: RST high for 3 cycles, then ENABLE = 1.
  - Response: all outputs 0 during reset; FLAG = 100, PHASE = 0 one cycle after ENABLE is sampled.
- Full wheel with DWELL = 2:
  - Stimulus: two pulses on the pacing channel per phase.
  - Response: PHASE steps 0→1→2→3→4→5→0 with the FLAG patterns listed under Operation; STEP fires exactly 6 times.
- Non-pacing pulses ignored:
  - Stimulus: in P0, pulse STT_G and STT_B 10 times each.
  - Response: PHASE stays 0 and STEP stays 0.
- Watchdog with TIMEOUT = 100 (RAINBOW_WATCHDOG_EN defined):
  - Stimulus: no STT pulses.
  - Response: PHASE becomes 1 exactly 100 cycles after RUN entry and FAULT = 1. A pacing STT coincident with cycle 100 advances the phase without setting FAULT.
- Mid-run disable:
  - Stimulus: in P3 with the dwell counter at 1, drop ENABLE for 1 cycle, then re-raise it.
  - Response: FLAG = 000, PHASE = 0 in IDLE; on restart, P0 needs the full DWELL pulses before advancing; FAULT is unchanged.
- Reset mid-run:
  - Stimulus: assert RST in P4 with FAULT = 1 and a coincident pacing STT pulse.
  - Response: after the edge, PHASE = 0, FLAG = 000, FAULT = 0, STEP = 0.
